// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths and constants for the instruction prefetch queue
package fetch_queue_pkg;
    localparam int          ADDR_W_DEF = 32;
    localparam int          INST_W_DEF = 32;
    localparam int          PC_STEP    = 4;
    localparam logic [31:0] NOP_INST   = 32'h0;
endpackage

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: synchronous FIFO of packed words with occupancy count and synchronous clear
module fq_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    always_comb begin
        wr_ptr_d = clr ? '0 : wr_ptr_q + PW'(wr_en);
        rd_ptr_d = clr ? '0 : rd_ptr_q + PW'(rd_en);
        count_d  = clr ? '0 : count_q + (PW+1)'(wr_en) - (PW+1)'(rd_en);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // storage is intentionally left unreset; occupancy alone decides validity
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = count_q == (PW+1)'(DEPTH);
    assign empty   = count_q == '0;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue owning the fetch PC, with redirect flush
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              deq_en,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pc4,
    output logic              full
);
    localparam int W = ADDR_W + INST_W;
    logic [ADDR_W-1:0]      fetch_pc_q, fetch_pc_d;
    logic [W-1:0]           head;
    logic [$clog2(DEPTH):0] count;
    logic                   empty, do_deq, do_enq;
    always_comb begin
        do_deq     = deq_en & out_valid;
        do_enq     = ~redirect & (~full | do_deq);
        fetch_pc_d = redirect ? (redirect_pc & ~ADDR_W'(3)) :
                     do_enq   ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc_q <= '0;
        else     fetch_pc_q <= fetch_pc_d;
    end
    fq_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (redirect),
        .wr_en   (do_enq),
        .wr_data ({fetch_pc_q, imem_data}),
        .rd_en   (do_deq),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );
    assign imem_addr = fetch_pc_q;
    assign out_valid = count != '0;
    assign out_inst  = empty ? INST_W'(NOP_INST) : head[INST_W-1:0];
    assign out_pc    = empty ? '0 : head[W-1:INST_W];
    assign out_pc4   = out_pc + ADDR_W'(PC_STEP);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench against a queue-based reference model
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        deq_en = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst, out_pc, out_pc4;
    logic        full;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic        full;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_q[$];
    logic [31:0] m_pc = '0;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .deq_en      (deq_en),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .full        (full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = mem_fn(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // reference model: the queue is a list of fetched PCs, the instruction is whatever memory holds there
    task automatic step(input bit rs, input bit rd, input logic [31:0] rpc, input bit dq);
        exp_t e;
        bit   deq, enq;
        @(negedge clk);
        rst = rs;
        redirect = rd;
        redirect_pc = rpc;
        deq_en = dq;
        if (rs) begin
            m_q.delete();
            m_pc = '0;
        end
        e.valid = m_q.size() > 0;
        e.pc    = e.valid ? m_q[0] : 32'h0;
        e.inst  = e.valid ? mem_fn(m_q[0]) : 32'h0;
        e.pc4   = e.pc + 32'd4;
        e.addr  = m_pc;
        e.full  = m_q.size() == 4;
        exp_q.push_back(e);
        if (!rs) begin
            if (rd) begin
                m_q.delete();
                m_pc = rpc & ~32'h3;
            end else begin
                deq = dq && m_q.size() > 0;
                enq = m_q.size() < 4 || deq;
                if (deq) void'(m_q.pop_front());
                if (enq) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(e.valid));
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", out_inst, e.inst);
                chk("out_pc4", out_pc4, e.pc4);
                chk("imem_addr", imem_addr, e.addr);
                chk("full", 32'(full), 32'(e.full));
            end
        end
    end

    initial begin
        step(1, 0, 0, 1);
        repeat (4) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h43, 0);
        repeat (3) step(0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0);
        step(0, 1, 32'h80, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 1, 32'hFFFF_FFF4, 0);
        repeat (6) step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        repeat (600) step($urandom_range(63) == 0, $urandom_range(11) == 0, $urandom, $urandom_range(9) < 7);
        @(negedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
